// File: rtl/int_logic_fu_pkg.sv
// rtl/int_logic_fu_pkg.sv - shared op codes, FSM states and width defaults for integer functional units
// Optional feature macro: INT_FU_SUB_EN (op 11 becomes subtract instead of NOR).
package int_logic_fu_pkg;

    localparam int DW_DEF    = 16;
    localparam int TAG_W_DEF = 3;
    localparam int CNT_W     = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
`ifdef INT_FU_SUB_EN
    localparam logic [1:0] OP_SUB = 2'b11;
`else
    localparam logic [1:0] OP_NOR = 2'b11;
`endif

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_WB   = 2'd3;

endpackage

// File: rtl/int_logic_alu.sv
// rtl/int_logic_alu.sv - combinational bitwise logic unit (op 11 is SUB under INT_FU_SUB_EN, else NOR)
module int_logic_alu
    import int_logic_fu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
`ifdef INT_FU_SUB_EN
            OP_SUB:  result_o = a_i - b_i;
`else
            OP_NOR:  result_o = ~(a_i | b_i);
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/int_logic_fu.sv
// rtl/int_logic_fu.sv - scoreboard integer logic unit: issue, operand read, timed execute, held write-back
// Optional feature macro: INT_FU_SUB_EN (selects subtract for op 11 inside int_logic_alu).
module int_logic_fu
    import int_logic_fu_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [TAG_W-1:0] issue_dest,
    output logic             issue_ready,
    input  logic             opnd_valid,
    input  logic [DW-1:0]    opnd_a,
    input  logic [DW-1:0]    opnd_b,
    output logic             busy,
    output logic             wr_req,
    output logic [TAG_W-1:0] wr_dest,
    output logic [DW-1:0]    wr_data,
    input  logic             wr_grant,
    input  logic             flush
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [TAG_W-1:0]   dest_q, dest_d;
    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      data_q, data_d;
    logic [DW-1:0]      alu_result;

    int_logic_alu #(.DW(DW)) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result)
    );

    // flush overrides every other input; inputs outside their state are ignored
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dest_d  = dest_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (issue_valid) begin
                    op_d    = issue_op;
                    dest_d  = issue_dest;
                    state_d = ST_READ;
                end
                ST_READ: if (opnd_valid) begin
                    a_d     = opnd_a;
                    b_d     = opnd_b;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_EXEC;
                end
                ST_EXEC: if (cnt_q == '0) begin
                    data_d  = alu_result;
                    state_d = ST_WB;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_WB: if (wr_grant) begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            dest_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign issue_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign wr_req      = (state_q == ST_WB);
    assign wr_dest     = dest_q;
    assign wr_data     = data_q;

endmodule
